aes_rkey_buf: RTL and testbench
===============================

# aes_rkey_buf

Round-key buffer that sits directly downstream of the key-expansion stage in the AES top level. On a load request it sequences the round index into key expansion and captures the NR+1 round keys it returns into a local register file. It then serves them by random access to the cipher/inverse-cipher datapath, with one-cycle read latency, so encryption (forward order) and decryption (reverse order) share one key schedule.

## Interface
- NR, 10, number of AES rounds; the buffer holds NR+1 keys (indices 0..NR).
- KEXP_LAT, 1, key-expansion latency: cycles from `kexp_round` = r being driven to `kexp_key` = K(r) being stable.
- clk  in  1  single clock for the block; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_load  in  1  single-cycle request to (re)build the schedule; the cipher key is already presented to key expansion.
- kexp_round  out  5  round index driven to key expansion.
- kexp_key  in  128  round key returned by key expansion.
- key_busy  out  1  high while the schedule is being filled.
- key_ready  out  1  high while all NR+1 keys are valid.
- rd_en  in  1  read request.
- rd_addr  in  4  round-key index to read.
- rd_valid  out  1  read response strobe, one cycle after `rd_en`.
- rd_key  out  128  round key read out; 0 on error.
- rd_err  out  1  qualifies `rd_valid`: the read was rejected.

## Operation
- Storage: NR+1 entries × 128-bit registers. Not cleared by reset; validity is tracked only by `key_ready`.
- State machine: IDLE, FILL, READY.
  - IDLE → FILL on `key_load`.
  - FILL → READY when entry NR is written.
  - READY → FILL on `key_load`.
  - FILL → FILL on `key_load`: restart from round 0.
- FILL issue:
  - On the edge that samples `key_load`, `kexp_round` becomes 0.
  - It increments by 1 on each following edge until it reaches NR, then holds at NR until FILL ends.
  - In IDLE/READY, `kexp_round` = 0.
- Capture:
  - A KEXP_LAT+1 deep issue pipeline (valid bit plus index) tags each issued round.
  - Entry r is written from `kexp_key` on edge E0+r+1+KEXP_LAT, where E0 is the `key_load` edge.
- Restart: `key_load` during FILL flushes the issue pipeline. No in-flight key from the old fill is written, and the fill starts over from round 0.
- Reads, evaluated against the state before the edge:
  - `key_ready`=1 and `rd_addr` ≤ NR: `rd_key` = entry[rd_addr], `rd_err`=0.
  - `key_ready`=0 (IDLE or FILL): `rd_err`=1, `rd_key`=0.
  - `rd_addr` > NR: `rd_err`=1, `rd_key`=0.
  - When `rd_en`=0, `rd_valid`=0 and `rd_key`/`rd_err` hold their previous values.
- Simultaneous `key_load` and `rd_en` in READY: the read returns the old key with no error; `key_ready` drops after that edge.
- Key expansion is never driven with an index above NR.

## Timing
- Reset values: `kexp_round`=0, `key_busy`=0, `key_ready`=0, `rd_valid`=0, `rd_key`=0, `rd_err`=0; state IDLE; issue pipeline cleared.
- Reset asserted mid-fill: returns immediately to IDLE; a new `key_load` is required.
- `key_busy` = 1 from edge E0 through the edge that writes entry NR, exclusive; `key_ready` = 1 from that edge.
- Fill latency: `key_ready` rises at edge E0+NR+1+KEXP_LAT, which is 12 cycles for the defaults.
- Read latency is exactly 1 cycle. Back-to-back reads are accepted every cycle with no stall; there is no backpressure.
- `kexp_round` and all outputs are registered.

## Test plan
- Fill: reset, then `key_load` with a model key expansion returning K(r) = {32'(r), 96'hA5} at latency 1.
  - Expect `kexp_round` sequence 0..10, then held at 10 until FILL ends, and 0 in READY.
  - Expect `key_busy` for 12 cycles, then `key_ready`=1.
- Forward/reverse read: in READY, read addr 0..10 back-to-back, then 10..0.
  - Expect `rd_valid` every cycle, each `rd_key` matching K(addr), `rd_err`=0.
- Error reads:
  - `rd_addr`=11 and 15 in READY → `rd_valid`=1, `rd_err`=1, `rd_key`=0.
  - Any read during FILL → `rd_err`=1, `rd_key`=0.
- Restart: second `key_load` 5 cycles into FILL with key model B.
  - Expect `kexp_round` to return to 0, and `key_ready` at 12 cycles after the second load.
  - Every entry must hold a B key; no A key may be captured.
- Simultaneous: `key_load` and `rd_en` (addr 3) on the same edge in READY.
  - The read returns old K(3), `rd_err`=0; `key_ready`=0 on the next cycle.
- Async reset: assert `reset_n`=0 mid-fill, between edges.
  - All outputs go to 0 immediately; after release, a read gives `rd_err`=1 until a new fill completes.

Source files
------------

// File: rtl/aes_rkey_buf_if.sv
// Bus between the round-key buffer, key expansion and the cipher datapath.
// The buffer uses the slave modport; the key-load/read requester uses master.
interface aes_rkey_buf_if;
  logic         key_load;
  logic [4:0]   kexp_round;
  logic [127:0] kexp_key;
  logic         key_busy;
  logic         key_ready;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err;

  modport slave (
    input  key_load, kexp_key, rd_en, rd_addr,
    output kexp_round, key_busy, key_ready, rd_valid, rd_key, rd_err
  );

  modport master (
    output key_load, kexp_key, rd_en, rd_addr,
    input  kexp_round, key_busy, key_ready, rd_valid, rd_key, rd_err
  );
endinterface

// File: rtl/aes_rkey_buf.sv
// Round-key buffer: sequences key expansion, captures NR+1 round keys and
// serves them by random access with one-cycle read latency.
module aes_rkey_buf #(
  parameter int NR       = 10,
  parameter int KEXP_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  aes_rkey_buf_if.slave bus
);

  localparam int                IDX_W    = $clog2(NR + 1);
  localparam logic [4:0]        NR_ROUND = 5'(NR);
  localparam logic [3:0]        NR_ADDR  = 4'(NR);
  localparam logic [IDX_W-1:0]  NR_IDX   = IDX_W'(NR);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} state_t;

  state_t                         state_q, state_d;
  logic [4:0]                     round_q;
  logic [KEXP_LAT:0]              pipe_v;
  logic [KEXP_LAT:0][IDX_W-1:0]   pipe_idx;
  logic [127:0]                   entry [NR+1];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             fill_done;
  logic [IDX_W-1:0] rd_idx;

  // The tail of the issue pipeline lines up with kexp_key; a key_load on the
  // same edge flushes whatever is in flight so no stale key is captured.
  assign wr_idx    = pipe_idx[KEXP_LAT];
  assign wr_en     = pipe_v[KEXP_LAT] && !bus.key_load;
  assign fill_done = wr_en && (wr_idx == NR_IDX);
  assign rd_idx    = IDX_W'(bus.rd_addr);

  assign bus.kexp_round = round_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.key_load) state_d = S_FILL;
      S_FILL: begin
        if (bus.key_load)   state_d = S_FILL;
        else if (fill_done) state_d = S_READY;
      end
      S_READY: if (bus.key_load) state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      pipe_v        <= '0;
      pipe_idx      <= '0;
      bus.key_busy  <= 1'b0;
      bus.key_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.key_busy  <= (state_d == S_FILL);
      bus.key_ready <= (state_d == S_READY);
      if (bus.key_load) begin
        round_q  <= '0;
        pipe_v   <= (KEXP_LAT + 1)'(1);
        pipe_idx <= '0;
      end else if (state_d == S_FILL) begin
        for (int i = 1; i <= KEXP_LAT; i++) begin
          pipe_v[i]   <= pipe_v[i-1];
          pipe_idx[i] <= pipe_idx[i-1];
        end
        // Stop issuing once round NR has gone out; hold the index there.
        if (round_q < NR_ROUND) begin
          round_q     <= round_q + 5'd1;
          pipe_v[0]   <= 1'b1;
          pipe_idx[0] <= IDX_W'(round_q + 5'd1);
        end else begin
          pipe_v[0]   <= 1'b0;
        end
      end else begin
        round_q <= '0;
        pipe_v  <= '0;
      end
    end
  end

  // NOTE: the key storage has no reset; key_ready alone says whether it is valid.
  always_ff @(posedge clk) begin
    if (wr_en) entry[wr_idx] <= bus.kexp_key;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_key   <= '0;
      bus.rd_err   <= 1'b0;
    end else if (bus.rd_en) begin
      bus.rd_valid <= 1'b1;
      if (bus.key_ready && (bus.rd_addr <= NR_ADDR)) begin
        bus.rd_key <= entry[rd_idx];
        bus.rd_err <= 1'b0;
      end else begin
        bus.rd_key <= '0;
        bus.rd_err <= 1'b1;
      end
    end else begin
      bus.rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_rkey_buf.sv
// Directed bench for aes_rkey_buf with a latency-1 key-expansion model.
module tb_aes_rkey_buf;

  logic clk = 1'b0;
  logic reset_n;
  bit   key_sel;
  int   n_checks = 0;
  int   n_errors = 0;

  aes_rkey_buf_if bus();

  aes_rkey_buf #(.NR(10), .KEXP_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] kmodel(input bit sel, input int r);
    return sel ? {32'(r), 96'hB6} : {32'(r), 96'hA5};
  endfunction

  // Key expansion: index driven after edge E gives its key after edge E+1.
  always @(posedge clk) bus.kexp_key <= kmodel(key_sel, int'(bus.kexp_round));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill;
    bus.key_load = 1'b1;
    step();
    bus.key_load = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_round", tag), 128'(bus.kexp_round), 128'd0);
    check($sformatf("%s_busy",  tag), 128'(bus.key_busy),   128'd0);
    check($sformatf("%s_ready", tag), 128'(bus.key_ready),  128'd0);
    check($sformatf("%s_valid", tag), 128'(bus.rd_valid),   128'd0);
    check($sformatf("%s_key",   tag), bus.rd_key,           128'd0);
    check($sformatf("%s_err",   tag), 128'(bus.rd_err),     128'd0);
  endtask

  task automatic do_read(input string tag, input int addr, input bit exp_err,
                         input logic [127:0] exp_key);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'(addr);
    step();
    check($sformatf("%s_valid%0d", tag, addr), 128'(bus.rd_valid), 128'd1);
    check($sformatf("%s_err%0d",   tag, addr), 128'(bus.rd_err),   128'(exp_err));
    check($sformatf("%s_key%0d",   tag, addr), bus.rd_key,         exp_key);
  endtask

  // Called right after the load edge E0; walks to E0+12 where key_ready rises.
  task automatic check_fill(input string tag);
    int exp_round;
    for (int c = 0; c <= 12; c++) begin
      exp_round = (c <= 10) ? c : ((c == 11) ? 10 : 0);
      check($sformatf("%s_round_c%0d", tag, c), 128'(bus.kexp_round), 128'(exp_round));
      check($sformatf("%s_busy_c%0d",  tag, c), 128'(bus.key_busy),   128'(c < 12));
      check($sformatf("%s_ready_c%0d", tag, c), 128'(bus.key_ready),  128'(c == 12));
      if (c == 4) begin
        check($sformatf("%s_fillrd_valid", tag), 128'(bus.rd_valid), 128'd1);
        check($sformatf("%s_fillrd_err",   tag), 128'(bus.rd_err),   128'd1);
        check($sformatf("%s_fillrd_key",   tag), bus.rd_key,         128'd0);
      end
      bus.rd_en   = (c == 3);
      bus.rd_addr = 4'd2;
      if (c < 12) step();
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    key_sel      = 1'b0;
    bus.key_load = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = 4'd0;
    repeat (3) step();
    check_all_zero("rst");
    reset_n = 1'b1;
    step();

    do_read("idle", 0, 1'b1, 128'd0);
    bus.rd_en = 1'b0;

    // Fill with key model A, then forward and reverse back-to-back reads.
    start_fill();
    check_fill("fillA");
    for (int a = 0; a <= 10; a++) do_read("fwdA", a, 1'b0, kmodel(1'b0, a));
    for (int a = 10; a >= 0; a--) do_read("revA", a, 1'b0, kmodel(1'b0, a));
    do_read("oob", 11, 1'b1, 128'd0);
    do_read("oob", 15, 1'b1, 128'd0);
    do_read("holdA", 5, 1'b0, kmodel(1'b0, 5));
    bus.rd_en = 1'b0;
    step();
    check("hold_valid", 128'(bus.rd_valid), 128'd0);
    check("hold_key",   bus.rd_key,         kmodel(1'b0, 5));
    check("hold_err",   128'(bus.rd_err),   128'd0);

    // Load and read on the same edge: the read sees the old schedule.
    bus.key_load = 1'b1;
    do_read("simul", 3, 1'b0, kmodel(1'b0, 3));
    bus.key_load = 1'b0;
    bus.rd_en    = 1'b0;
    check("simul_ready", 128'(bus.key_ready), 128'd0);
    check("simul_busy",  128'(bus.key_busy),  128'd1);
    repeat (4) step();
    check("pre_restart_round", 128'(bus.kexp_round), 128'd4);

    // Restart five cycles into the fill with key model B.
    key_sel = 1'b1;
    start_fill();
    check_fill("fillB");
    for (int a = 0; a <= 10; a++) do_read("fwdB", a, 1'b0, kmodel(1'b1, a));
    bus.rd_en = 1'b0;

    // Asynchronous reset between edges in the middle of a fill.
    key_sel = 1'b0;
    start_fill();
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1 check_all_zero("arst");
    #2 reset_n = 1'b1;
    repeat (15) step();
    check("post_rst_ready", 128'(bus.key_ready),  128'd0);
    check("post_rst_busy",  128'(bus.key_busy),   128'd0);
    check("post_rst_round", 128'(bus.kexp_round), 128'd0);
    do_read("post_rst", 0, 1'b1, 128'd0);
    bus.rd_en = 1'b0;

    start_fill();
    repeat (12) step();
    check("refill_ready", 128'(bus.key_ready), 128'd1);
    do_read("refill", 10, 1'b0, kmodel(1'b0, 10));
    bus.rd_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
